// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: acknowledges each received byte,
// buffers it for the CPU, and reports sticky overrun plus a level interrupt.
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned THRESHOLD = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    rx_rdy_clr,
  input  logic                    rd_en,
  output logic [7:0]              rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overrun,
  input  logic                    overrun_clr,
  input  logic                    flush,
  output logic                    irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          ack_q;
  logic          irq_q, irq_d;
  logic          cap, push, pop, drop;

  // The ack gate keeps the byte still presented during its ack cycle from being taken twice.
  assign cap   = rx_rdy & ~ack_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = cap & (~full | rd_en) & ~flush;
  assign pop   = rd_en & ~empty & ~flush;
  assign drop  = cap & full & ~rd_en & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear must leave the flag set.
      if (overrun_clr) overrun_d = 1'b0;
      if (drop)        overrun_d = 1'b1;
    end
    irq_d = (count_d >= CW'(THRESHOLD)) | overrun_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      ack_q     <= cap;
      irq_q     <= irq_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_data;
  end

  assign rd_data    = mem[rd_ptr_q];
  assign rx_rdy_clr = ack_q;
  assign count      = count_q;
  assign overrun    = overrun_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned THRESHOLD = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       overrun_clr;
  logic       flush;
  logic       irq;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  bit         ov_m;
  bit         ack_m;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .flush      (flush),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("rx_rdy_clr", 32'(rx_rdy_clr), 32'(ack_m));
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("overrun", 32'(overrun), 32'(ov_m));
    chk("irq", 32'(irq), 32'((n >= THRESHOLD) || ov_m));
    if (n > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
  endtask

  // Advance the reference model by one clock using the current inputs, then compare.
  task automatic cycle();
    bit cap;
    bit drop;
    int n;
    cap  = rx_rdy && !ack_m;
    n    = q.size();
    drop = 1'b0;
    if (flush) begin
      q.delete();
      ov_m = 1'b0;
    end else begin
      if (rd_en && n > 0) void'(q.pop_front());
      if (cap) begin
        if (n < DEPTH || rd_en) q.push_back(rx_data);
        else drop = 1'b1;
      end
      if (overrun_clr) ov_m = 1'b0;
      if (drop) ov_m = 1'b1;
    end
    ack_m = cap;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Receiver presents a byte, sees it taken, and drops rdy at the end of the ack cycle.
  task automatic rx_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    cycle();
    cycle();
    rx_rdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    q.delete();
    ov_m  = 1'b0;
    ack_m = 1'b0;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    bit last_clr;
    bit clr_now;
    reset       = 1'b1;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    rd_en       = 1'b0;
    overrun_clr = 1'b0;
    flush       = 1'b0;
    ov_m        = 1'b0;
    ack_m       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // 1: single byte held until acknowledged
    rx_byte(8'hA5);
    cycle();
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_data", 32'(rd_data), 32'hA5);
    flush = 1'b1; cycle(); flush = 1'b0;

    // 2: fill, overflow, drain in order, then clear overrun
    for (int i = 0; i < 16; i++) rx_byte(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    rx_byte(8'h55);
    chk("t2_overrun", 32'(overrun), 32'd1);
    rd_en = 1'b1;
    repeat (16) cycle();
    rd_en = 1'b0;
    cycle();
    chk("t2_irq_held", 32'(irq), 32'd1);
    overrun_clr = 1'b1; cycle(); overrun_clr = 1'b0;

    // 3: push on full with a simultaneous pop
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h20 + i));
    rx_rdy  = 1'b1;
    rx_data = 8'h77;
    rd_en   = 1'b1;
    cycle();
    rd_en = 1'b0;
    cycle();
    rx_rdy = 1'b0;
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_overrun", 32'(overrun), 32'd0);
    rd_en = 1'b1;
    repeat (15) cycle();
    chk("t3_last", 32'(rd_data), 32'h77);
    cycle();

    // 4: back-to-back bytes, then pops on empty
    rd_en = 1'b0;
    rx_byte(8'h11);
    rx_byte(8'h22);
    chk("t4_count", 32'(count), 32'd2);
    rd_en = 1'b1;
    repeat (4) cycle();
    rd_en = 1'b0;
    rx_byte(8'h3C);
    chk("t4_after_empty_pop", 32'(rd_data), 32'h3C);

    // 5: flush with a concurrent capture
    for (int i = 0; i < 4; i++) rx_byte(8'(8'h40 + i));
    rx_rdy  = 1'b1;
    rx_data = 8'h99;
    flush   = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    rx_rdy = 1'b0;
    chk("t5_empty", 32'(empty), 32'd1);
    cycle();

    // 6: asynchronous reset mid-fill with rdy still high afterwards
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h60 + i));
    rd_en = 1'b1;
    repeat (9) cycle();
    rd_en = 1'b0;
    chk("t6_pre_count", 32'(count), 32'd7);
    rx_rdy  = 1'b1;
    rx_data = 8'hC3;
    do_reset();
    cycle();
    cycle();
    rx_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd_en = (i % 3) != 0;
      rx_byte(8'(i * 7 + 3));
    end
    rd_en = 1'b1;
    repeat (20) cycle();
    rd_en = 1'b0;

    // Randomized traffic: fill-biased first half, drain-biased second half
    last_clr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!rx_rdy || last_clr) begin
        rx_rdy  = $urandom_range(0, 99) < 70;
        rx_data = 8'($urandom);
      end
      rd_en       = $urandom_range(0, 99) < ((i < 300) ? 20 : 65);
      overrun_clr = $urandom_range(0, 15) == 0;
      flush       = $urandom_range(0, 79) == 0;
      clr_now     = ack_m;
      cycle();
      last_clr = clr_now;
    end
    rx_rdy      = 1'b0;
    rd_en       = 1'b0;
    overrun_clr = 1'b0;
    flush       = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
